// File: rtl/rs_shared_pkg.sv
// Shared constants for the resource-shared dual add unit.
package rs_shared_pkg;

    // Default operand / sum width.
    localparam int unsigned RS_W_DEFAULT = 1;

endpackage : rs_shared_pkg

// File: rtl/rs_shared_if.sv
// Operand, select and result bundle for rs_shared.
//   a..f          : W-bit operands (pairs AB, CD, EF)
//   s1, s2        : path selects (s1: AB/CD, s2: CD/EF)
//   c1_out, y_out : registered carry/sum of path 1
//   c2_out, z_out : registered carry/sum of path 2
// master drives operands and selects; slave (the adder unit) drives results.
interface rs_shared_if
    import rs_shared_pkg::*;
#(
    parameter int unsigned W = RS_W_DEFAULT
);

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [W-1:0] e;
    logic [W-1:0] f;
    logic         s1;
    logic         s2;
    logic         c1_out;
    logic         c2_out;
    logic [W-1:0] y_out;
    logic [W-1:0] z_out;

    modport master (
        output a, b, c, d, e, f, s1, s2,
        input  c1_out, c2_out, y_out, z_out
    );

    modport slave (
        input  a, b, c, d, e, f, s1, s2,
        output c1_out, c2_out, y_out, z_out
    );

endinterface : rs_shared_if

// File: rtl/rs_shared_add.sv
// Selectable adder: muxes the operand pair first, then performs one (W+1)-bit add.
//   sel_i       : 0 selects x0_i + y0_i, 1 selects x1_i + y1_i
//   x0_i, y0_i  : operand pair 0
//   x1_i, y1_i  : operand pair 1
//   carry_c_o   : combinational carry-out of the selected sum
//   sum_c_o     : combinational low W bits of the selected sum
module rs_shared_add
    import rs_shared_pkg::*;
#(
    parameter int unsigned W = RS_W_DEFAULT
) (
    input  logic         sel_i,
    input  logic [W-1:0] x0_i,
    input  logic [W-1:0] y0_i,
    input  logic [W-1:0] x1_i,
    input  logic [W-1:0] y1_i,
    output logic         carry_c_o,
    output logic [W-1:0] sum_c_o
);

    logic [W:0] opx;
    logic [W:0] opy;
    logic [W:0] res;

    // Operand mux ahead of the single adder, zero-extended to carry width.
    assign opx = {1'b0, (sel_i ? x1_i : x0_i)};
    assign opy = {1'b0, (sel_i ? y1_i : y0_i)};

    assign res       = opx + opy;
    assign carry_c_o = res[W];
    assign sum_c_o   = res[W-1:0];

endmodule : rs_shared_add

// File: rtl/rs_shared.sv
// Resource-shared dual add unit with registered results (one-cycle latency).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears all four result registers
//   bus  : slave side of rs_shared_if (operands, selects, results)
// Path 1 adds AB or CD (s1), path 2 adds CD or EF (s2); one adder per path.
module rs_shared
    import rs_shared_pkg::*;
#(
    parameter int unsigned W = RS_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    rs_shared_if.slave  bus
);

    logic         c1_d;
    logic         c1_q;
    logic [W-1:0] y_d;
    logic [W-1:0] y_q;
    logic         c2_d;
    logic         c2_q;
    logic [W-1:0] z_d;
    logic [W-1:0] z_q;

    // Path 1: s1=0 -> a+b, s1=1 -> c+d.
    rs_shared_add #(
        .W (W)
    ) u_add_p1 (
        .sel_i     (bus.s1),
        .x0_i      (bus.a),
        .y0_i      (bus.b),
        .x1_i      (bus.c),
        .y1_i      (bus.d),
        .carry_c_o (c1_d),
        .sum_c_o   (y_d)
    );

    // Path 2: s2=0 -> c+d, s2=1 -> e+f.
    rs_shared_add #(
        .W (W)
    ) u_add_p2 (
        .sel_i     (bus.s2),
        .x0_i      (bus.c),
        .y0_i      (bus.d),
        .x1_i      (bus.e),
        .y1_i      (bus.f),
        .carry_c_o (c2_d),
        .sum_c_o   (z_d)
    );

    // Result registers; reset wins over the live update.
    always_ff @(posedge clk) begin
        if (rst) begin
            c1_q <= 1'b0;
            y_q  <= '0;
            c2_q <= 1'b0;
            z_q  <= '0;
        end else begin
            c1_q <= c1_d;
            y_q  <= y_d;
            c2_q <= c2_d;
            z_q  <= z_d;
        end
    end

    assign bus.c1_out = c1_q;
    assign bus.y_out  = y_q;
    assign bus.c2_out = c2_q;
    assign bus.z_out  = z_q;

endmodule : rs_shared

// File: tb/tb_rs_shared.sv
// Bench for rs_shared: W=1 vector table plus hand sequences for latency and W=8 overflow.
module tb_rs_shared;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rs_shared_if #(.W(1)) bus1 ();
    rs_shared_if #(.W(8)) bus8 ();

    rs_shared #(.W(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    rs_shared #(.W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    typedef struct {
        logic rst;
        logic a, b, c, d, e, f;
        logic s1, s2;
        logic ec1, ey, ec2, ez;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check1(input string tag);
        check({tag, ".c1"}, int'(bus1.c1_out), 0);
    endtask

    task automatic drive8(input int a, input int b, input int c, input int d,
                          input int e, input int f, input logic s1, input logic s2);
        bus8.a  = 8'(a);
        bus8.b  = 8'(b);
        bus8.c  = 8'(c);
        bus8.d  = 8'(d);
        bus8.e  = 8'(e);
        bus8.f  = 8'(f);
        bus8.s1 = s1;
        bus8.s2 = s2;
    endtask

    task automatic check8(input string tag, input int c1, input int y, input int c2, input int z);
        check({tag, ".c1"}, int'(bus8.c1_out), c1);
        check({tag, ".y"},  int'(bus8.y_out),  y);
        check({tag, ".c2"}, int'(bus8.c2_out), c2);
        check({tag, ".z"},  int'(bus8.z_out),  z);
    endtask

    initial begin
        //          rst  a  b  c  d  e  f  s1 s2   c1 y  c2 z
        vecs[0]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1,   0, 0, 0, 0}; // reset, all ones
        vecs[1]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1,   0, 0, 0, 0}; // reset, second cycle
        vecs[2]  = '{0, 1, 1, 1, 1, 1, 1, 1, 1,   1, 0, 1, 0}; // release: c+d, e+f
        vecs[3]  = '{0, 1, 0, 1, 1, 0, 0, 0, 0,   0, 1, 1, 0}; // p1 a+b=1, p2 c+d=2
        vecs[4]  = '{0, 1, 0, 1, 1, 0, 0, 1, 0,   1, 0, 1, 0}; // p1 c+d=2
        vecs[5]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0,   0, 0, 0, 1}; // p2 c+d=1
        vecs[6]  = '{0, 0, 0, 0, 1, 1, 1, 0, 1,   0, 0, 1, 0}; // p2 e+f=2
        vecs[7]  = '{0, 1, 1, 1, 0, 1, 1, 1, 0,   0, 1, 0, 1}; // shared CD pair
        vecs[8]  = '{0, 1, 1, 1, 0, 1, 1, 0, 0,   1, 0, 0, 1}; // s1 toggles, z unchanged
        vecs[9]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1,   0, 0, 0, 0}; // reset mid-stream
        vecs[10] = '{0, 0, 1, 0, 0, 0, 1, 0, 1,   0, 1, 0, 1}; // a+b=1, e+f=1
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0}; // all zero

        rst = 1'b1;
        drive8(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // Table: drive on falling edge, sample on the following falling edge.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst     = vecs[i].rst;
            bus1.a  = vecs[i].a;
            bus1.b  = vecs[i].b;
            bus1.c  = vecs[i].c;
            bus1.d  = vecs[i].d;
            bus1.e  = vecs[i].e;
            bus1.f  = vecs[i].f;
            bus1.s1 = vecs[i].s1;
            bus1.s2 = vecs[i].s2;
            @(negedge clk);
            check($sformatf("vec%0d.c1", i), int'(bus1.c1_out), int'(vecs[i].ec1));
            check($sformatf("vec%0d.y",  i), int'(bus1.y_out),  int'(vecs[i].ey));
            check($sformatf("vec%0d.c2", i), int'(bus1.c2_out), int'(vecs[i].ec2));
            check($sformatf("vec%0d.z",  i), int'(bus1.z_out),  int'(vecs[i].ez));
        end

        // Latency: a mid-cycle change of a is only seen after the next rising edge.
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.c = 1'b0; bus1.d = 1'b0;
        bus1.e = 1'b0; bus1.f = 1'b0; bus1.s1 = 1'b0; bus1.s2 = 1'b0;
        @(negedge clk);
        check("lat.y_loaded", int'(bus1.y_out), 1);
        #1 bus1.a = 1'b0;
        #2 check("lat.y_hold", int'(bus1.y_out), 1);
        @(posedge clk);
        #1 check("lat.y_after_edge", int'(bus1.y_out), 0);

        // W=8 overflow and wrap.
        @(negedge clk);
        drive8(200, 100, 10, 20, 255, 1, 1'b0, 1'b1);
        @(negedge clk);
        check8("w8.ovf", 1, 44, 1, 0);

        drive8(200, 100, 10, 20, 255, 1, 1'b1, 1'b0);
        @(negedge clk);
        check8("w8.cd", 0, 30, 0, 30);

        drive8(255, 255, 10, 20, 128, 127, 1'b0, 1'b1);
        @(negedge clk);
        check8("w8.max", 1, 254, 0, 255);

        // Reset mid-stream with live operands still applied.
        rst = 1'b1;
        @(negedge clk);
        check8("w8.rst", 0, 0, 0, 0);

        rst = 1'b0;
        @(negedge clk);
        check8("w8.reload", 1, 254, 0, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rs_shared

// File: doc/rs_shared.md
Name: rs_shared

Overview:
- Resource-shared dual add unit: two independent 1-of-2 selectable additions.
- Each output path uses a single adder whose operands are multiplexed before the add. There is no adder per candidate sum followed by a result mux.
- Sits in datapath glue logic wherever a selectable sum-with-carry is needed.
- Results are registered: one-cycle latency.

Parameters:
- W, 1, width of every data operand and of each sum output (carry is always 1 bit).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  W  operand A (pair AB)
- b  input  W  operand B (pair AB)
- c  input  W  operand C (pair CD)
- d  input  W  operand D (pair CD)
- e  input  W  operand E (pair EF)
- f  input  W  operand F (pair EF)
- s1  input  1  select for path 1: 0 = a+b, 1 = c+d
- s2  input  1  select for path 2: 0 = c+d, 1 = e+f
- c1_out  output  1  carry-out of path 1
- c2_out  output  1  carry-out of path 2
- y_out  output  W  sum of path 1 (low W bits)
- z_out  output  W  sum of path 2 (low W bits)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: on a rising clk edge with rst=1, c1_out, y_out, c2_out and z_out all become 0. Reset has priority over any update.
- Path 1, operand muxing:
  - op1x = s1 ? c : a
  - op1y = s1 ? d : b
  - {c1_out, y_out} <= op1x + op1y, computed at (W+1) bits, unsigned.
- Path 2, operand muxing:
  - op2x = s2 ? e : c
  - op2y = s2 ? f : d
  - {c2_out, z_out} <= op2x + op2y, computed at (W+1) bits, unsigned.
- Latency:
  - Outputs reflect inputs and selects sampled at the previous rising edge. No enable; the registers update every cycle when rst=0.
  - Between edges the outputs are stable, independent of input changes.
- Adder count:
  - Exactly one (W+1)-bit adder per path, two in total.
  - Operand muxes precede the adders. The synthesized netlist must not contain four adders.
- Arithmetic:
  - Unsigned, no saturation.
  - Wrap-around is expressed via the carry. Example at W=1: 1+1 gives carry 1, sum 0.
- Path independence:
  - Paths are fully independent; s1 never affects path 2 and vice versa.
  - Both paths may select the CD pair simultaneously (s1=1, s2=0). They must then produce identical results in the same cycle.
- Reset mid-operation: any cycle with rst=1 forces zeros on the next edge. The first edge after rst deasserts loads live results.
- No internal state beyond the four output registers.

Decomposition:
- Package rs_shared_pkg holds only the default width constant (RS_W_DEFAULT = 1); no typedefs are required.
- One sub-module is natural: rs_shared_add (parameter W), used twice.
  - Inputs: sel, x0, y0, x1, y1.
  - Outputs: combinational {carry, sum} = sel ? x1+y1 : x0+y0.
  - Internally it muxes the operands first, then performs a single add.
- The top level instantiates rs_shared_add twice and owns the output registers and reset.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all inputs=1, s1=s2=1 -> all outputs 0. Release rst -> next edge c1/y=1/0, c2/z=1/0.
- Path 1 select, W=1, a=1, b=0, c=1, d=1:
  - s1=0 -> c1_out=0, y_out=1 one cycle later.
  - s1=1 -> c1_out=1, y_out=0.
- Path 2 select, W=1, c=0, d=1, e=1, f=1:
  - s2=0 -> c2_out=0, z_out=1.
  - s2=1 -> c2_out=1, z_out=0.
- Shared pair: s1=1, s2=0, c=1, d=0 -> both paths give carry 0, sum 1 in the same cycle. Toggling s1 to 0 leaves z_out unchanged.
- Latency check: change a mid-cycle -> y_out changes only at the next rising edge, exactly one cycle after sampling.
- W=8 overflow:
  - a=200, b=100, s1=0 -> c1_out=1, y_out=44.
  - e=255, f=1, s2=1 -> c2_out=1, z_out=0.
  - rst asserted mid-stream -> zeros on the next edge.
